// File: rtl/fir_seq_pkg.sv
// Shared types and register map for the 4-tap FIR control sequencer.
// Micro-op codes, FSM states and register-file indices live here.
package fir_seq_pkg;

   localparam int SEQ_OP_W   = 3;
   localparam int SEQ_REG_AW = 4;

   typedef enum logic [SEQ_OP_W-1:0] {
      NOP   = 3'd0,
      COPY  = 3'd1,
      LOAD1 = 3'd2,
      LOAD2 = 3'd3,
      ADD   = 3'd4,
      SUB   = 3'd5,
      MUL   = 3'd6
   } op_t;

   typedef enum logic [4:0] {
      IDLE, EIDLE, STORE, ZERO,
      SORT1, SORT2, SORT3, SORT4,
      MUL1, ADD1, MUL2, SUB2, MUL3, ADD3, MUL4, SUB4,
      LDC, WAITC
   } state_t;

   localparam logic [SEQ_REG_AW-1:0] R_ACC    = 4'd0;
   localparam logic [SEQ_REG_AW-1:0] R_S1     = 4'd1;
   localparam logic [SEQ_REG_AW-1:0] R_S2     = 4'd2;
   localparam logic [SEQ_REG_AW-1:0] R_S3     = 4'd3;
   localparam logic [SEQ_REG_AW-1:0] R_S4     = 4'd4;
   localparam logic [SEQ_REG_AW-1:0] R_F0     = 4'd5;
   localparam logic [SEQ_REG_AW-1:0] R_F1     = 4'd6;
   localparam logic [SEQ_REG_AW-1:0] R_F2     = 4'd7;
   localparam logic [SEQ_REG_AW-1:0] R_F3     = 4'd8;
   localparam logic [SEQ_REG_AW-1:0] R_TMP_IN = 4'd9;
   localparam logic [SEQ_REG_AW-1:0] R_TMP_P  = 4'd10;

   // States whose ALU op can raise overflow (the multiply-accumulate chain).
   function automatic logic is_arith(input state_t s);
      return s inside {MUL1, ADD1, MUL2, SUB2, MUL3, ADD3, MUL4, SUB4};
   endfunction

endpackage

// File: rtl/fir_seq_decode.sv
// Pure combinational decode of a sequencer state into its ALU micro-op fields.
// Fields not used by a state stay 0.
module fir_seq_decode
   import fir_seq_pkg::*;
(
   input  state_t                  i_state,
   input  logic [1:0]              i_idx,
   output op_t                     o_op,
   output logic [SEQ_REG_AW-1:0]   o_src1,
   output logic [SEQ_REG_AW-1:0]   o_src2,
   output logic [SEQ_REG_AW-1:0]   o_dest,
   output logic                    o_cnt_up,
   output logic                    o_clear
);

   always_comb begin
      // NOTE: every output gets a default before the case, so no path can infer a latch.
      o_op     = NOP;
      o_src1   = '0;
      o_src2   = '0;
      o_dest   = '0;
      o_cnt_up = 1'b0;
      o_clear  = 1'b0;
      case (i_state)
         STORE: begin o_op = LOAD1; o_dest = R_TMP_IN; o_cnt_up = 1'b1; end
         ZERO:  begin o_op = SUB;   o_src1 = R_ACC; o_src2 = R_ACC; o_dest = R_ACC; end
         SORT1: begin o_op = COPY;  o_src1 = R_S3;     o_dest = R_S4; end
         SORT2: begin o_op = COPY;  o_src1 = R_S2;     o_dest = R_S3; end
         SORT3: begin o_op = COPY;  o_src1 = R_S1;     o_dest = R_S2; end
         SORT4: begin o_op = COPY;  o_src1 = R_TMP_IN; o_dest = R_S1; end
         MUL1:  begin o_op = MUL;   o_src1 = R_S1;  o_src2 = R_F0;    o_dest = R_TMP_P; end
         ADD1:  begin o_op = ADD;   o_src1 = R_ACC; o_src2 = R_TMP_P; o_dest = R_ACC; end
         MUL2:  begin o_op = MUL;   o_src1 = R_S2;  o_src2 = R_F1;    o_dest = R_TMP_P; end
         SUB2:  begin o_op = SUB;   o_src1 = R_ACC; o_src2 = R_TMP_P; o_dest = R_ACC; end
         MUL3:  begin o_op = MUL;   o_src1 = R_S3;  o_src2 = R_F2;    o_dest = R_TMP_P; end
         ADD3:  begin o_op = ADD;   o_src1 = R_ACC; o_src2 = R_TMP_P; o_dest = R_ACC; end
         MUL4:  begin o_op = MUL;   o_src1 = R_S4;  o_src2 = R_F3;    o_dest = R_TMP_P; end
         SUB4:  begin o_op = SUB;   o_src1 = R_ACC; o_src2 = R_TMP_P; o_dest = R_ACC; end
         LDC: begin
            o_op    = LOAD2;
            o_dest  = R_F0 + {2'b00, i_idx};
            o_clear = (i_idx == 2'd0);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/fir_sequencer.sv
// Control FSM for the 4-tap FIR datapath: sample MAC sequence and coefficient loads.
// Define FIR_SEQ_STICKY_ERR_EN to keep err set until n_rst instead of clearing it per sample.
module fir_sequencer
   import fir_seq_pkg::*;
#(
   parameter int OP_W   = SEQ_OP_W,
   parameter int REG_AW = SEQ_REG_AW
)(
   input  logic              clk,
   input  logic              n_rst,
   input  logic              data_ready,
   input  logic              load_coeff,
   input  logic [1:0]        coeff_num,
   input  logic              overflow,
   output logic [OP_W-1:0]   op,
   output logic [REG_AW-1:0] src1,
   output logic [REG_AW-1:0] src2,
   output logic [REG_AW-1:0] dest,
   output logic              modwait,
   output logic              cnt_up,
   output logic              clear,
   output logic              err
);

   state_t     r_state;
   state_t     w_next;
   logic       r_err;
   logic       w_err_next;
   logic       r_ret;
   logic       r_modwait;
   logic [1:0] r_idx;
   logic       w_take_coeff;

   op_t                   w_op;
   logic [SEQ_REG_AW-1:0] w_src1;
   logic [SEQ_REG_AW-1:0] w_src2;
   logic [SEQ_REG_AW-1:0] w_dest;

   always_comb begin
      w_next       = r_state;
      w_err_next   = r_err;
      w_take_coeff = 1'b0;
      case (r_state)
         IDLE, EIDLE: begin
            if (data_ready) begin
               w_next = STORE;
            end else if (load_coeff) begin
               w_next       = LDC;
               w_take_coeff = 1'b1;
            end
         end
         STORE: begin
            if (!data_ready) begin
               w_next     = EIDLE;
               w_err_next = 1'b1;
            end else begin
               w_next = ZERO;
            end
         end
         ZERO: begin
            w_next = SORT1;
`ifdef FIR_SEQ_STICKY_ERR_EN
            w_err_next = r_err;
`else
            w_err_next = 1'b0;
`endif
         end
         SORT1: w_next = SORT2;
         SORT2: w_next = SORT3;
         SORT3: w_next = SORT4;
         SORT4: w_next = MUL1;
         MUL1:  w_next = ADD1;
         ADD1:  w_next = MUL2;
         MUL2:  w_next = SUB2;
         SUB2:  w_next = MUL3;
         MUL3:  w_next = ADD3;
         ADD3:  w_next = MUL4;
         MUL4:  w_next = SUB4;
         SUB4:  w_next = IDLE;
         LDC:   w_next = WAITC;
         WAITC: w_next = r_ret ? EIDLE : IDLE;
         default: w_next = IDLE;
      endcase
      // Any overflow during the MAC chain aborts the sample.
      if (is_arith(r_state) && overflow) begin
         w_next     = EIDLE;
         w_err_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state   <= IDLE;
         r_err     <= 1'b0;
         r_ret     <= 1'b0;
         r_modwait <= 1'b0;
         r_idx     <= 2'd0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         r_state   <= w_next;
         r_err     <= w_err_next;
         r_modwait <= !(w_next inside {IDLE, EIDLE});
         // coeff_num is captured here because the loader advances it on this same edge.
         if (w_take_coeff) begin
            r_idx <= coeff_num;
            r_ret <= (r_state == EIDLE);
         end
      end
   end

   fir_seq_decode u_decode (
      .i_state  (r_state),
      .i_idx    (r_idx),
      .o_op     (w_op),
      .o_src1   (w_src1),
      .o_src2   (w_src2),
      .o_dest   (w_dest),
      .o_cnt_up (cnt_up),
      .o_clear  (clear)
   );

   assign op      = OP_W'(w_op);
   assign src1    = REG_AW'(w_src1);
   assign src2    = REG_AW'(w_src2);
   assign dest    = REG_AW'(w_dest);
   assign modwait = r_modwait;
   assign err     = r_err;

endmodule

// File: doc/fir_sequencer.md
Name: fir_sequencer

Overview:
- Control FSM for the 4-tap FIR datapath.
- For each incoming sample it issues one register-file/ALU micro-op per cycle: store, shift history, multiply-accumulate.
- Services coefficient-load requests from the coefficient loader.
- Drives modwait back to the loader and the host.
- Flags arithmetic overflow and data-ready protocol errors.

Parameters:
- OP_W, 3, width of op field.
- REG_AW, 4, register-file address width (16 registers).

Ports:
- clk  input  1  clock.
- n_rst  input  1  asynchronous active-low reset.
- data_ready  input  1  new sample present on datapath input; level, held by host.
- load_coeff  input  1  one-cycle request to load coefficient coeff_num.
- coeff_num  input  2  coefficient index; valid with load_coeff.
- overflow  input  1  datapath ALU overflow, combinational, valid in the same cycle as the op.
- op  output  OP_W  micro-op: NOP=0, COPY=1, LOAD1=2 (sample), LOAD2=3 (coeff), ADD=4, SUB=5, MUL=6.
- src1  output  REG_AW  ALU source 1.
- src2  output  REG_AW  ALU source 2.
- dest  output  REG_AW  ALU destination.
- modwait  output  1  busy; registered.
- cnt_up  output  1  one-cycle pulse per accepted sample.
- clear  output  1  one-cycle pulse at start of new coefficient set.
- err  output  1  error flag.

Behaviour:
- Register map:
  - R0 = accumulator.
  - R1..R4 = sample history, R1 newest.
  - R5..R8 = F0..F3.
  - R9 = incoming-sample temp; R10 = product temp.
- Reset: state IDLE, modwait 0, err 0, ret flag 0, idx 0. op NOP, src/dest 0, cnt_up 0, clear 0.
- op/src/dest/cnt_up/clear are a combinational decode of the current state. Unlisted fields are 0.
- modwait flop is loaded each clock with (next_state not in {IDLE, EIDLE}).
- States, one cycle each unless stated:
  - IDLE / EIDLE: NOP.
    - data_ready -> STORE.
    - Otherwise load_coeff -> LDC; latch idx<=coeff_num; ret flag <= (state==EIDLE).
    - data_ready wins if both are high.
  - STORE: LOAD1 dest R9; cnt_up=1.
    - If data_ready is low in this cycle -> EIDLE with err<=1.
    - Otherwise -> ZERO.
  - ZERO: SUB R0<=R0-R0. err<=0, i.e. a new sample clears err.
  - SORT1..SORT4: COPY R4<=R3, R3<=R2, R2<=R1, R1<=R9.
  - MUL1 R10<=R1*R5; ADD1 R0<=R0+R10.
  - MUL2 R10<=R2*R6; SUB2 R0<=R0-R10.
  - MUL3 R10<=R3*R7; ADD3 R0<=R0+R10.
  - MUL4 R10<=R4*R8; SUB4 R0<=R0-R10.
    - Overflow high in any MUL/ADD/SUB state -> EIDLE, err<=1.
    - SUB4 without overflow -> IDLE.
  - LDC: LOAD2 dest = 5+idx; clear=1 iff idx==0 -> WAITC.
  - WAITC: NOP -> EIDLE if ret flag else IDLE.
- Latency:
  - Sample path: data_ready seen in IDLE to return to IDLE = 14 cycles; modwait high exactly 14 cycles, starting one cycle after data_ready is sampled.
  - Coefficient load: modwait high 2 cycles.
- idx is latched in IDLE because the loader increments coeff_num on the same edge it pulses load_coeff.
- load_coeff while busy is ignored; the loader only asserts it while modwait=0.
- err is held through EIDLE and through coefficient loads started from EIDLE.
- Reset mid-operation: asynchronous return to reset values; no partial op is completed.

Optional Feature:
- Macro: FIR_SEQ_STICKY_ERR_EN.
- Defined: once set, err clears only on n_rst; ZERO does not clear it. Sequencing is otherwise unchanged.
- Undefined: err clears in ZERO, as described above.

Decomposition:
- Package fir_seq_pkg holds:
  - op_t enum (NOP..MUL).
  - state_t enum.
  - Register index constants R_ACC=0, R_S1..R_S4=1..4, R_F0=5, R_TMP_IN=9, R_TMP_P=10.
- Sub-module fir_seq_decode: pure combinational state_t -> op/src1/src2/dest/cnt_up/clear. It takes idx and is reused by the bench as a reference model.

Test Plan:
- Coefficient load:
  - Stimulus: load_coeff pulses with coeff_num 0..3 in IDLE, each waiting for modwait low.
  - Required: op=3 with dest=5,6,7,8; clear=1 only on dest 5; modwait high 2 cycles each.
- Normal sample:
  - Stimulus: data_ready held 2 cycles, overflow=0.
  - Required: the 14-op sequence with exact src/dest (STORE dest9 … SUB4 src1 0 src2 10 dest0); cnt_up one pulse; modwait high 14 cycles; err=0.
- Overflow:
  - Stimulus: overflow=1 during ADD3.
  - Required: next state EIDLE, err=1, modwait=0.
  - Then a new data_ready: err=0 after ZERO (without macro); err stays 1 with FIR_SEQ_STICKY_ERR_EN.
- Protocol error:
  - Stimulus: data_ready for 1 cycle only.
  - Required: STORE sees it low -> err=1, EIDLE, no ZERO op issued.
- Load from error state:
  - Stimulus: load_coeff in EIDLE with coeff_num=2.
  - Required: LOAD2 dest 7, then return to EIDLE with err still 1.
- Reset mid-operation:
  - Stimulus: n_rst asserted during MUL2, and data_ready+load_coeff asserted together in IDLE.
  - Required: immediate reset values on reset; with both inputs high, the sample path is taken and load_coeff is dropped.
